// File: rtl/pps_nal_extractor_if.sv
// rtl/pps_nal_extractor_if.sv - Annex-B byte stream handshake into the PPS NAL extractor.
interface pps_nal_extractor_if;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;

    modport master (output in_byte, output in_valid, output in_last, input  in_ready);
    modport slave  (input  in_byte, input  in_valid, input  in_last, output in_ready);
endinterface

// File: rtl/pps_nal_extractor.sv
// rtl/pps_nal_extractor.sv - Finds PPS NAL units in an Annex-B stream, strips emulation bytes, packs the RBSP MSB-first.
module pps_nal_extractor #(
    parameter int MAX_BYTES = 384,
    parameter int PPS_TYPE  = 34
) (
    input  logic                   clk,
    input  logic                   reset,
    pps_nal_extractor_if.slave     s_in,
    output logic [MAX_BYTES*8-1:0] pps_bitstream,
    output logic [8:0]             pps_len,
    output logic                   pps_valid,
    output logic                   err,
    output logic [1:0]             err_code
);

    localparam int         BW     = MAX_BYTES * 8;
    localparam logic [9:0] MAX_L  = 10'(MAX_BYTES);
    localparam logic [5:0] TYPE_L = 6'(PPS_TYPE);

    typedef enum logic [2:0] {
        S_SYNC,
        S_HDR0,
        S_HDR1,
        S_PAY,
        S_SKIP,
        S_COMMIT
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    zcnt_q, zcnt_d;
    logic [8:0]    wr_ptr_q, wr_ptr_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [BW-1:0] bits_q, bits_d;
    logic [8:0]    len_q, len_d;
    logic          last_q, last_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic [7:0]    b;
    logic [1:0]    p;
    logic          start, acc, wr_en;
    logic [9:0]    wr_idx, sum_w, sum_e;

    assign s_in.in_ready = (state_q != S_COMMIT);
    assign pps_bitstream = bits_q;
    assign pps_len       = len_q;
    assign pps_valid     = valid_q;
    assign err           = err_q;
    assign err_code      = code_q;

    always_comb begin
        state_d  = state_q;
        zcnt_d   = zcnt_q;
        wr_ptr_d = wr_ptr_q;
        buf_d    = buf_q;
        bits_d   = bits_q;
        len_d    = len_q;
        last_d   = last_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        code_d   = 2'd0;
        wr_en    = 1'b0;

        b      = s_in.in_byte;
        p      = zcnt_q[1] ? 2'd2 : zcnt_q;
        start  = (b == 8'h01) && zcnt_q[1];
        acc    = s_in.in_valid && (state_q != S_COMMIT);
        wr_idx = {1'b0, wr_ptr_q} + {8'd0, p};
        sum_w  = wr_idx + 10'd1;
        sum_e  = {1'b0, wr_ptr_q} + 10'd2;

        if (state_q == S_COMMIT) begin
            state_d = last_q ? S_SYNC : S_HDR0;
        end else if (acc) begin
            zcnt_d = (b != 8'h00) ? 2'd0 : ((zcnt_q == 2'd3) ? 2'd3 : zcnt_q + 2'd1);
            case (state_q)
                S_SYNC, S_SKIP: begin
                    if (start) state_d = S_HDR0;
                end
                S_HDR0: begin
                    if (b[7] || (b[6:1] != TYPE_L)) begin
                        state_d = S_SKIP;
                    end else begin
                        buf_d    = '0;
                        wr_ptr_d = '0;
                        state_d  = S_HDR1;
                    end
                end
                S_HDR1: begin
                    state_d = (b[2:0] == 3'd0) ? S_SKIP : S_PAY;
                end
                S_PAY: begin
                    // Zeros stay pending in zcnt; the buffer is pre-cleared, so
                    // writing them only means advancing the pointer past them.
                    if (b == 8'h00) begin
                        state_d = S_PAY;
                    end else if ((b == 8'h03) && (zcnt_q == 2'd2)) begin
                        if (sum_e > MAX_L) begin
                            err_d   = 1'b1;
                            code_d  = 2'd1;
                            state_d = S_SKIP;
                        end else begin
                            wr_ptr_d = sum_e[8:0];
                        end
                    end else if (start) begin
                        state_d = S_COMMIT;
                    end else if (zcnt_q == 2'd3) begin
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                        state_d = S_SYNC;
                    end else if (sum_w > MAX_L) begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = S_SKIP;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = sum_w[8:0];
                    end
                    if (s_in.in_last && (state_d == S_PAY)) state_d = S_COMMIT;
                end
                default: state_d = S_SYNC;
            endcase

            if (s_in.in_last && (state_d != S_COMMIT)) state_d = S_SYNC;

            if (wr_en) buf_d = buf_q | ({b, {(BW-8){1'b0}}} >> {wr_idx, 3'b000});

            // Outputs are loaded on entry so pps_valid is seen during S_COMMIT.
            if (state_d == S_COMMIT) begin
                last_d = s_in.in_last;
                zcnt_d = 2'd0;
                if (wr_ptr_d == 9'd0) begin
                    err_d  = 1'b1;
                    code_d = 2'd3;
                end else begin
                    valid_d = 1'b1;
                    bits_d  = buf_d;
                    len_d   = wr_ptr_d;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_SYNC;
            zcnt_q   <= 2'd0;
            wr_ptr_q <= 9'd0;
            buf_q    <= '0;
            bits_q   <= '0;
            len_q    <= 9'd0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            zcnt_q   <= zcnt_d;
            wr_ptr_q <= wr_ptr_d;
            buf_q    <= buf_d;
            bits_q   <= bits_d;
            len_q    <= len_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

endmodule

// File: doc/pps_nal_extractor.md
Name: pps_nal_extractor

Overview:
- Upstream stage of the PPS decoder: scans the camera's Annex-B HEVC byte stream for start codes and identifies PPS NAL units (nal_unit_type 34).
- Strips emulation-prevention bytes and packs the PPS RBSP MSB-first into the 3072-bit bitstream word the PPS decoder consumes.
- Pulses `pps_valid` when a complete PPS is committed. Non-PPS NAL units are skipped.

Parameters:
- MAX_BYTES, 384, capacity of the RBSP buffer in bytes (MAX_BYTES*8 = 3072 = output width)
- PPS_TYPE, 34, nal_unit_type value that selects a NAL for capture

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous reset, active-low
- in_byte  input  8  stream byte
- in_valid  input  1  in_byte valid
- in_ready  output  1  byte accepted when in_valid & in_ready
- in_last  input  1  qualifies the accepted byte as the final byte of the stream
- pps_bitstream  output  3072  committed RBSP; byte k at bits [3071-8k -: 8]; unused bytes zero
- pps_len  output  9  committed RBSP byte count (1..MAX_BYTES)
- pps_valid  output  1  one-cycle pulse: pps_bitstream/pps_len just updated
- err  output  1  one-cycle error pulse
- err_code  output  2  1 = overflow, 2 = syntax (illegal zero run), 3 = empty PPS; valid with err

Behaviour:
- Reset (reset low, asynchronous):
  - state = S_SYNC, zcnt = 0, wr_ptr = 0, work buffer = 0.
  - pps_bitstream = 0, pps_len = 0, pps_valid = 0, err = 0, err_code = 0, in_ready = 1.
  - Reset mid-NAL discards the partial NAL. The last committed PPS is lost.
- Outputs are registered:
  - pps_bitstream and pps_len change only in the S_COMMIT cycle.
  - They hold stable between pps_valid pulses.
- in_ready is 1 in every state except S_COMMIT, where it is 0. No other stall exists.
- zcnt: count of consecutive 0x00 bytes accepted, saturating at 3.
  - Cleared by any non-zero byte.
  - 0x00 bytes are never written immediately; they are held pending in zcnt.
- Start code: a byte 0x01 accepted with zcnt >= 2.
- States:
  - S_SYNC: on start code -> S_HDR0; everything else is ignored.
  - S_HDR0: header byte 0 taken raw.
    - If bit7 = 1 (forbidden_zero) or bits[6:1] != PPS_TYPE -> S_SKIP.
    - Otherwise clear the work buffer, set wr_ptr = 0 -> S_HDR1.
  - S_HDR1: header byte 1.
    - If bits[2:0] == 0 (temporal_id_plus1) -> S_SKIP.
    - Otherwise -> S_PAY.
  - S_PAY: per accepted byte b, with p = min(zcnt, 2) pending zeros:
    - b == 0x00: zcnt++, nothing written.
    - b == 0x03 and zcnt == 2: write 2 zeros, drop b, zcnt = 0.
    - b == 0x01 and zcnt >= 2: terminating start code; discard pending zeros -> S_COMMIT.
    - zcnt == 3 and b != 0x01: err, code 2 -> S_SYNC, no commit.
    - Otherwise: write p zeros then b at wr_ptr.. in the same cycle; wr_ptr += p+1; zcnt = 0.
    - If a write would make wr_ptr exceed MAX_BYTES: err, code 1 -> S_SKIP, nothing written.
  - S_SKIP: on start code -> S_HDR0.
  - S_COMMIT (one cycle):
    - If wr_ptr == 0: err, code 3, no pps_valid.
    - Otherwise pps_bitstream = work buffer, pps_len = wr_ptr, pps_valid = 1.
    - Next state: S_HDR0 if entered via start code; S_SYNC if entered via in_last.
- in_last:
  - In S_PAY, the byte is processed normally, then -> S_COMMIT. Pending zeros are discarded as trailing zeros.
  - In any other state -> S_SYNC.
  - If the in_last byte itself is a start code 0x01, the NAL is committed and the state returns to S_SYNC.
- Latency: pps_valid is asserted in the cycle after the terminating byte (start-code 0x01 or in_last byte) is accepted.
- Back-to-back PPS NALs: the second header byte may be presented in the cycle after S_COMMIT. in_ready is 0 during S_COMMIT, so no byte is lost.
- Exact fill: wr_ptr == MAX_BYTES is legal. The next write overflows.

Test Plan:
- Stream 00 00 01 44 01 C1 72 -> pps_valid one cycle after 0x72 is accepted with in_last; pps_len = 2; pps_bitstream[3071:3056] = 16'hC172, rest 0.
- PPS payload C0 00 00 03 01 80 followed by 00 00 01 -> RBSP C0 00 00 01 80, pps_len = 5; next byte 0x40 enters S_HDR0.
- 00 00 00 01 40 01 (VPS) FF FF, then 00 00 01 44 01 AA with in_last -> VPS skipped; exactly one pps_valid with pps_len = 1, data AA.
- PPS with 385 non-zero payload bytes -> err = 1, err_code = 1 on byte 385; no pps_valid; previous pps_bitstream unchanged; next PPS captured normally.
- PPS payload 11 00 00 00 22 -> err, err_code = 2 on 0x22; state S_SYNC. Also PPS header followed directly by a start code -> err_code = 3, no pps_valid.
- Assert reset low mid-payload for 1 cycle, then send a valid PPS -> all outputs 0 during reset; only the new PPS is committed.
